// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic operators: FSM state encodings and counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Bit counter must be able to represent 0..N.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in) -> d (difference bit), bout (borrow out).
module full_subtractor_1bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // Borrow when a<b outright, or when a==b and a borrow is already pending.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_n_bit_subtractor.sv
// Bit-serial LSB-first N-bit unsigned subtractor Z = X - Y with borrow-out.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+N; one op per N+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
// Ports: clk, rst (sync active-high), start, X, Y in; busy, done, Z, B_out out (all registered).
module serial_n_bit_subtractor
   import arith_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] X,
   input  logic [N-1:0] Y,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] Z,
   output logic         B_out
);

   localparam int            CW       = cnt_width(N);
   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [N-1:0]  r_xs;
   logic [N-1:0]  r_ys;
   logic [N-1:0]  r_zs;
   logic          r_borrow;
   logic [CW-1:0] r_cnt;

   logic          w_d;
   logic          w_bnext;
   logic          w_last;
   logic          w_load;
   logic          w_step;
   logic [N-1:0]  w_res;

   full_subtractor_1bit u_fs (
      .a    (r_xs[0]),
      .b    (r_ys[0]),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_bnext)
   );

   // New difference bit enters at the MSB; after N steps bit 0 has reached position 0.
   // Written as a shift of the concatenation so it also holds for N=1.
   assign w_res  = N'({w_d, r_zs} >> 1);
   assign w_last = (r_cnt == LAST_BIT);

   // Next-state and datapath control decode.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_step = 1'b1;
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register; busy/done are flopped from the next state so they track r_state exactly
   // while remaining free of any combinational decode at the port.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         busy    <= (w_state_nxt != ST_IDLE);
         done    <= (w_state_nxt == ST_DONE);
      end
   end

   // Shift registers, borrow flop, bit counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_xs     <= '0;
         r_ys     <= '0;
         r_zs     <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         Z        <= '0;
         B_out    <= 1'b0;
      end else if (w_load) begin
         r_xs     <= X;
         r_ys     <= Y;
         r_zs     <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else if (w_step) begin
         r_xs     <= r_xs >> 1;
         r_ys     <= r_ys >> 1;
         r_zs     <= w_res;
         r_borrow <= w_bnext;
         r_cnt    <= r_cnt + CW'(1);
         // Published results only move on the final bit, so Z/B_out hold steady otherwise.
         if (w_last) begin
            Z     <= w_res;
            B_out <= w_bnext;
         end
      end
   end

endmodule
